// File: rtl/pipeline_pkg.sv
// Shared pipeline types: register width default, hazard FSM states,
// and hazard-cause codes also used by the forwarding debug path.
package pipeline_pkg;

  localparam int DEF_REG_ADDR_W = 5;

  typedef enum logic {
    RUN,
    BR_STALL2
  } hz_state_t;

  typedef enum logic [2:0] {
    HZ_NONE,
    HZ_LOAD_USE,
    HZ_BR_ALU,
    HZ_BR_LOAD,
    HZ_BR_LOAD_MEM,
    HZ_BR_HOLD
  } hz_cause_t;

endpackage

// File: rtl/hazard_stall_counter.sv
// Saturating stall-cycle counter; only present when
// HAZARD_STALL_CNT_EN is defined.
`ifdef HAZARD_STALL_CNT_EN
module hazard_stall_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule
`endif

// File: rtl/hazard_detection_unit.sv
// ID-stage stall/flush controller for load-use and branch hazards.
// Optional stall counter built when HAZARD_STALL_CNT_EN is defined.
module hazard_detection_unit
  import pipeline_pkg::*;
#(
  parameter int REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] IF_ID_Rs,
  input  logic [REG_ADDR_W-1:0] IF_ID_Rt,
  input  logic                  IF_ID_UsesRt,
  input  logic                  IF_ID_Branch,
  input  logic                  branch_taken,
  input  logic [REG_ADDR_W-1:0] ID_EXE_Rd,
  input  logic                  ID_EXE_RegWrite,
  input  logic                  ID_EXE_MemRead,
  input  logic [REG_ADDR_W-1:0] EXE_MEM_Rd,
  input  logic                  EXE_MEM_MemRead,
  input  logic                  ext_stall,
  output logic                  PC_Write,
  output logic                  IF_ID_Write,
  output logic                  ID_EXE_Bubble,
  output logic                  IF_ID_Flush,
  output logic [CNT_W-1:0]      stall_count
);

  hz_state_t state, state_n;
  hz_cause_t cause;

  logic m_exe, m_mem;
  logic lu, br_alu, br_ld, br_mem;
  logic stall;

  assign m_exe = (ID_EXE_Rd != '0) &&
                 ((ID_EXE_Rd == IF_ID_Rs) ||
                  (IF_ID_UsesRt && (ID_EXE_Rd == IF_ID_Rt)));
  assign m_mem = (EXE_MEM_Rd != '0) &&
                 ((EXE_MEM_Rd == IF_ID_Rs) ||
                  (IF_ID_UsesRt && (EXE_MEM_Rd == IF_ID_Rt)));

  assign lu     = ID_EXE_MemRead && m_exe;
  assign br_alu = IF_ID_Branch && ID_EXE_RegWrite &&
                  !ID_EXE_MemRead && m_exe;
  assign br_ld  = IF_ID_Branch && ID_EXE_MemRead && m_exe;
  assign br_mem = IF_ID_Branch && EXE_MEM_MemRead && m_mem;

  // Branch-load wins so the FSM gets its second stall cycle.
  always_comb begin
    cause = HZ_NONE;
    if (state == BR_STALL2)  cause = HZ_BR_HOLD;
    else if (br_ld)          cause = HZ_BR_LOAD;
    else if (br_mem)         cause = HZ_BR_LOAD_MEM;
    else if (br_alu)         cause = HZ_BR_ALU;
    else if (lu)             cause = HZ_LOAD_USE;
  end

  assign stall = (cause != HZ_NONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (!ext_stall) begin
      unique case (state)
        RUN: begin
          if (cause == HZ_BR_LOAD) state_n = BR_STALL2;
        end
        BR_STALL2: state_n = RUN;
        default:   state_n = RUN;
      endcase
    end
  end

  always_comb begin
    PC_Write      = 1'b1;
    IF_ID_Write   = 1'b1;
    ID_EXE_Bubble = 1'b0;
    IF_ID_Flush   = 1'b0;
    if (!rst_n) begin
      PC_Write      = 1'b0;
      IF_ID_Write   = 1'b0;
      ID_EXE_Bubble = 1'b1;
    end else if (ext_stall) begin
      PC_Write      = 1'b0;
      IF_ID_Write   = 1'b0;
    end else begin
      PC_Write      = !stall;
      IF_ID_Write   = !stall;
      ID_EXE_Bubble = stall;
      IF_ID_Flush   = IF_ID_Branch && branch_taken && !stall;
    end
  end

`ifdef HAZARD_STALL_CNT_EN
  hazard_stall_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall && !ext_stall),
    .count (stall_count)
  );
`else
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Directed scoreboard bench for hazard_detection_unit.
module tb_hazard_detection_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  IF_ID_Rs, IF_ID_Rt, ID_EXE_Rd, EXE_MEM_Rd;
  logic        IF_ID_UsesRt, IF_ID_Branch, branch_taken;
  logic        ID_EXE_RegWrite, ID_EXE_MemRead, EXE_MEM_MemRead;
  logic        ext_stall;
  logic        PC_Write, IF_ID_Write, ID_EXE_Bubble, IF_ID_Flush;
  logic [31:0] stall_count;

  typedef struct {
    string tag;
    logic  pc;
    logic  ifid;
    logic  bub;
    logic  fl;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] cnt_model = '0;

  always #5 clk = ~clk;

  hazard_detection_unit #(
    .REG_ADDR_W (5),
    .CNT_W      (32)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .IF_ID_Rs        (IF_ID_Rs),
    .IF_ID_Rt        (IF_ID_Rt),
    .IF_ID_UsesRt    (IF_ID_UsesRt),
    .IF_ID_Branch    (IF_ID_Branch),
    .branch_taken    (branch_taken),
    .ID_EXE_Rd       (ID_EXE_Rd),
    .ID_EXE_RegWrite (ID_EXE_RegWrite),
    .ID_EXE_MemRead  (ID_EXE_MemRead),
    .EXE_MEM_Rd      (EXE_MEM_Rd),
    .EXE_MEM_MemRead (EXE_MEM_MemRead),
    .ext_stall       (ext_stall),
    .PC_Write        (PC_Write),
    .IF_ID_Write     (IF_ID_Write),
    .ID_EXE_Bubble   (ID_EXE_Bubble),
    .IF_ID_Flush     (IF_ID_Flush),
    .stall_count     (stall_count)
  );

  task automatic idle();
    IF_ID_Rs        = 5'd0;
    IF_ID_Rt        = 5'd0;
    IF_ID_UsesRt    = 1'b0;
    IF_ID_Branch    = 1'b0;
    branch_taken    = 1'b0;
    ID_EXE_Rd       = 5'd0;
    ID_EXE_RegWrite = 1'b0;
    ID_EXE_MemRead  = 1'b0;
    EXE_MEM_Rd      = 5'd0;
    EXE_MEM_MemRead = 1'b0;
    ext_stall       = 1'b0;
  endtask

  task automatic nxt();
    @(negedge clk);
    idle();
  endtask

  task automatic chk(input string tag, input string what,
                     input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s %s observed %0h expected %0h",
             tag, what, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic pc,
                      input logic ifid, input logic bub,
                      input logic fl);
    exp_t e;
    e.tag  = tag;
    e.pc   = pc;
    e.ifid = ifid;
    e.bub  = bub;
    e.fl   = fl;
    sbq.push_back(e);
  endtask

  // Inputs settle, then the oldest expectation is popped and compared.
  task automatic step(input string tag, input logic pc,
                      input logic ifid, input logic bub,
                      input logic fl);
    exp_t        e;
    logic [31:0] ec;
    push(tag, pc, ifid, bub, fl);
    #1;
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s scoreboard empty observed 0 expected 1", tag);
    end else begin
      e = sbq.pop_front();
      if (!rst_n) cnt_model = '0;
`ifdef HAZARD_STALL_CNT_EN
      ec = cnt_model;
`else
      ec = '0;
`endif
      chk(e.tag, "PC_Write",      {31'd0, PC_Write},      {31'd0, e.pc});
      chk(e.tag, "IF_ID_Write",   {31'd0, IF_ID_Write},   {31'd0, e.ifid});
      chk(e.tag, "ID_EXE_Bubble", {31'd0, ID_EXE_Bubble}, {31'd0, e.bub});
      chk(e.tag, "IF_ID_Flush",   {31'd0, IF_ID_Flush},   {31'd0, e.fl});
      chk(e.tag, "stall_count",   stall_count,            ec);
      if (rst_n && e.bub && !ext_stall && cnt_model != '1)
        cnt_model = cnt_model + 32'd1;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle();

    nxt(); step("reset0", 0, 0, 1, 0);
    nxt(); step("reset1", 0, 0, 1, 0);
    nxt(); rst_n = 1'b1;
    step("idle", 1, 1, 0, 0);

    nxt();
    ID_EXE_MemRead = 1'b1; ID_EXE_Rd = 5'd5; IF_ID_Rs = 5'd5;
    step("load_use", 0, 0, 1, 0);
    nxt(); step("load_use_after", 1, 1, 0, 0);

    nxt();
    IF_ID_Branch = 1'b1; ID_EXE_MemRead = 1'b1; ID_EXE_Rd = 5'd8;
    IF_ID_Rt = 5'd8; IF_ID_UsesRt = 1'b1;
    step("br_load_c1", 0, 0, 1, 0);
    nxt(); step("br_load_c2", 0, 0, 1, 0);
    nxt(); step("br_load_after", 1, 1, 0, 0);

    nxt();
    IF_ID_Branch = 1'b1; branch_taken = 1'b1; IF_ID_Rs = 5'd3;
    IF_ID_Rt = 5'd4; IF_ID_UsesRt = 1'b1;
    ID_EXE_Rd = 5'd9; ID_EXE_RegWrite = 1'b1;
    step("taken_flush", 1, 1, 0, 1);
    nxt(); step("taken_after", 1, 1, 0, 0);

    nxt();
    ID_EXE_MemRead = 1'b1; ID_EXE_Rd = 5'd0; IF_ID_Rs = 5'd0;
    step("reg0", 1, 1, 0, 0);

    nxt();
    ID_EXE_MemRead = 1'b1; ID_EXE_Rd = 5'd10; IF_ID_Rt = 5'd10;
    IF_ID_Rs = 5'd1; IF_ID_UsesRt = 1'b0;
    step("rt_unused", 1, 1, 0, 0);

    nxt();
    IF_ID_Branch = 1'b1; branch_taken = 1'b1; ID_EXE_RegWrite = 1'b1;
    ID_EXE_Rd = 5'd6; IF_ID_Rs = 5'd6;
    step("br_alu", 0, 0, 1, 0);
    nxt(); step("br_alu_after", 1, 1, 0, 0);

    nxt();
    IF_ID_Branch = 1'b1; EXE_MEM_MemRead = 1'b1; EXE_MEM_Rd = 5'd7;
    IF_ID_Rt = 5'd7; IF_ID_UsesRt = 1'b1;
    step("br_load_mem", 0, 0, 1, 0);
    nxt(); step("br_load_mem_after", 1, 1, 0, 0);

    nxt();
    IF_ID_Branch = 1'b1; ID_EXE_MemRead = 1'b1; ID_EXE_Rd = 5'd12;
    IF_ID_Rs = 5'd12;
    step("ext_br_c1", 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      nxt(); ext_stall = 1'b1;
      step("ext_hold", 0, 0, 0, 0);
    end
    nxt(); step("ext_br_c2", 0, 0, 1, 0);
    nxt(); step("ext_br_after", 1, 1, 0, 0);

    nxt();
    ext_stall = 1'b1; IF_ID_Branch = 1'b1; ID_EXE_MemRead = 1'b1;
    ID_EXE_Rd = 5'd13; IF_ID_Rs = 5'd13; branch_taken = 1'b1;
    step("ext_no_sample", 0, 0, 0, 0);
    nxt(); step("ext_no_sample_after", 1, 1, 0, 0);

    nxt();
    IF_ID_Branch = 1'b1; ID_EXE_MemRead = 1'b1; ID_EXE_Rd = 5'd14;
    IF_ID_Rs = 5'd14;
    step("rst_br_c1", 0, 0, 1, 0);
    nxt(); rst_n = 1'b0;
    step("rst_mid", 0, 0, 1, 0);
    nxt(); rst_n = 1'b1;
    step("rst_release", 1, 1, 0, 0);
    nxt(); step("rst_no_residual", 1, 1, 0, 0);

    nxt();
    IF_ID_Branch = 1'b1; branch_taken = 1'b1; IF_ID_Rs = 5'd2;
    step("taken_again", 1, 1, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_detection_unit.md
# hazard_detection_unit

Stall and flush controller for the ID stage of the 5-stage MIPS pipeline. It is the counterpart to ALU operand forwarding: it covers the dependencies forwarding cannot resolve. Those are load-use and branch-operand hazards. It freezes PC and IF/ID, injects bubbles into ID/EXE, and flushes IF/ID on taken branches. A small FSM sequences multi-cycle branch stalls. An optional counter records stall cycles.

## Interface
- REG_ADDR_W, 5, register-number width
- CNT_W, 32, stall-counter width (used only with the counter compiled in)

- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- IF_ID_Rs, IF_ID_Rt  in  REG_ADDR_W  source registers of the instruction in ID
- IF_ID_UsesRt  in  1  the ID instruction reads Rt (R-type, beq/bne, sw)
- IF_ID_Branch  in  1  the ID instruction is beq/bne, compared in ID
- branch_taken  in  1  ID comparator result, valid when IF_ID_Branch=1
- ID_EXE_Rd  in  REG_ADDR_W  destination register of the instruction in EXE
- ID_EXE_RegWrite, ID_EXE_MemRead  in  1  EXE-stage control bits
- EXE_MEM_Rd  in  REG_ADDR_W  destination register of the instruction in MEM
- EXE_MEM_MemRead  in  1  MEM-stage load flag
- ext_stall  in  1  data-memory not ready; freezes the whole pipeline
- PC_Write  out  1  PC may update
- IF_ID_Write  out  1  IF/ID may update
- ID_EXE_Bubble  out  1  zero the control fields written into ID/EXE
- IF_ID_Flush  out  1  replace IF/ID with a nop
- stall_count  out  CNT_W  stall-cycle counter (see Configuration)

## Operation
- Match definition: match(X) = (X != 0) && (X == IF_ID_Rs || (IF_ID_UsesRt && X == IF_ID_Rt)).
- Load-use: ID_EXE_MemRead && match(ID_EXE_Rd).
- Branch-ALU: IF_ID_Branch && ID_EXE_RegWrite && !ID_EXE_MemRead && match(ID_EXE_Rd).
- Branch-load: IF_ID_Branch && ID_EXE_MemRead && match(ID_EXE_Rd). This needs 2 stall cycles.
- Branch-load-MEM: IF_ID_Branch && EXE_MEM_MemRead && match(EXE_MEM_Rd).
- FSM states:
  - RUN: branch-load → BR_STALL2. Any other hazard → stall this cycle and stay in RUN. No hazard → no stall.
  - BR_STALL2: stall unconditionally → RUN.
- Priority: if a load-use and a branch hazard are both present, branch-load takes precedence.
- stall = (state==BR_STALL2) || any hazard in RUN.
- When stall=1 and ext_stall=0: PC_Write=0, IF_ID_Write=0, ID_EXE_Bubble=1.
- IF_ID_Flush = IF_ID_Branch && branch_taken && !stall && !ext_stall.
- ext_stall=1: PC_Write=0, IF_ID_Write=0, ID_EXE_Bubble=0, IF_ID_Flush=0. The FSM holds its state and no hazard is re-sampled into state.
- Outputs are combinational from state and inputs (Mealy). Only the state and the counter are registered.

## Timing
- Hazard outputs assert in the same cycle the hazard is visible on the inputs, with zero latency. The stall takes effect at the next clk edge.
- Load-use: 1 stall cycle. Branch-ALU: 1 cycle. Branch-load: 2 cycles (RUN cycle plus BR_STALL2). Branch-load-MEM alone: 1 cycle.
- Reset (rst_n low, asynchronous): state=RUN and stall_count=0 immediately. While reset is asserted: PC_Write=0, IF_ID_Write=0, ID_EXE_Bubble=1, IF_ID_Flush=0.
- Deassertion: normal operation starts at the first clk edge after rst_n goes high.
- Reset asserted while in BR_STALL2 aborts the stall. No residual stall cycle follows reset.
- Register 0 never causes a hazard.

## Configuration
- HAZARD_STALL_CNT_EN defined: stall_count increments by 1 on each clk edge where stall=1 and ext_stall=0. It saturates at all-ones and does not wrap.
- HAZARD_STALL_CNT_EN undefined: stall_count is tied to 0, no counter flops are built, and CNT_W is unused.

## Structure
- pipeline_pkg holds the REG_ADDR_W default, the hz_state_t enum {RUN, BR_STALL2}, and the hazard-cause codes shared with the forwarding logic for debug.
- Sub-module hazard_stall_counter holds the saturating counter. It is instantiated only under HAZARD_STALL_CNT_EN.

## Test plan
- Load-use: ID_EXE_MemRead=1, ID_EXE_Rd=5, IF_ID_Rs=5 → one cycle of PC_Write=0, IF_ID_Write=0, ID_EXE_Bubble=1; normal operation on the next cycle; stall_count=1.
- Branch-load: IF_ID_Branch=1, ID_EXE_MemRead=1, ID_EXE_Rd=8, IF_ID_Rt=8, IF_ID_UsesRt=1 → stall for 2 consecutive cycles, state goes RUN→BR_STALL2→RUN, stall_count=2.
- Taken branch with no hazard: IF_ID_Branch=1, branch_taken=1, unrelated registers → IF_ID_Flush=1 for one cycle; PC_Write=1 and IF_ID_Write=1 throughout.
- Register 0: ID_EXE_MemRead=1, ID_EXE_Rd=0, IF_ID_Rs=0 → no stall.
- ext_stall raised for 3 cycles while in BR_STALL2 → Bubble=0 and state stays BR_STALL2. After ext_stall drops: exactly one more stall cycle; counter does not advance during ext_stall.
- rst_n pulsed low mid-BR_STALL2 → outputs take reset values at once, state=RUN, stall_count=0, no stall after release.
